// File: rtl/arc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arc_ctrl_pkg
// Description : Shared encodings for the ARC MIPS multicycle main control:
//               FSM states, opcode classes, opcodes, AluOp / Other codes and
//               datapath mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
package arc_ctrl_pkg;

    // Main FSM states; codes 12..15 are unreachable and recover to FETCH
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_I_WB     = 4'd5,
        ST_BRANCH   = 4'd6,
        ST_JUMP     = 4'd7,
        ST_MEM_ADDR = 4'd8,
        ST_MEM_RD   = 4'd9,
        ST_MEM_WB   = 4'd10,
        ST_MEM_WR   = 4'd11
    } state_t;

    // Instruction class latched in DECODE; CLS_R is the reset value
    typedef enum logic [3:0] {
        CLS_R   = 4'd0,
        CLS_J   = 4'd1,
        CLS_JAL = 4'd2,
        CLS_BEQ = 4'd3,
        CLS_BNE = 4'd4,
        CLS_I   = 4'd5,
        CLS_LW  = 4'd6,
        CLS_SW  = 4'd7,
        CLS_ILL = 4'd8
    } op_class_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'd0;
    localparam logic [5:0] c_op_j     = 6'd2;
    localparam logic [5:0] c_op_jal   = 6'd3;
    localparam logic [5:0] c_op_beq   = 6'd4;
    localparam logic [5:0] c_op_bne   = 6'd5;
    localparam logic [5:0] c_op_addi  = 6'd8;
    localparam logic [5:0] c_op_addiu = 6'd9;
    localparam logic [5:0] c_op_slti  = 6'd10;
    localparam logic [5:0] c_op_sltiu = 6'd11;
    localparam logic [5:0] c_op_andi  = 6'd12;
    localparam logic [5:0] c_op_ori   = 6'd13;
    localparam logic [5:0] c_op_xori  = 6'd14;
    localparam logic [5:0] c_op_lui   = 6'd15;
    localparam logic [5:0] c_op_lw    = 6'd35;
    localparam logic [5:0] c_op_sw    = 6'd43;

    // AluOp codes consumed by ALU control
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_other = 2'b11;

    // Other codes shared with ALU control
    localparam logic [3:0] c_other_add = 4'd0;
    localparam logic [3:0] c_other_and = 4'd1;
    localparam logic [3:0] c_other_or  = 4'd2;
    localparam logic [3:0] c_other_xor = 4'd3;
    localparam logic [3:0] c_other_bne = 4'd5;
    localparam logic [3:0] c_other_slt = 4'd6;
    localparam logic [3:0] c_other_lui = 4'd7;
    localparam logic [3:0] c_other_jal = 4'd8;

    // PC source mux
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;
    localparam logic [1:0] c_pcsrc_rs     = 2'b11;

    // Register destination mux
    localparam logic [1:0] c_regdst_rt = 2'b00;
    localparam logic [1:0] c_regdst_rd = 2'b01;
    localparam logic [1:0] c_regdst_ra = 2'b10;

    // Writeback data mux
    localparam logic [1:0] c_m2r_aluout = 2'b00;
    localparam logic [1:0] c_m2r_mdr    = 2'b01;
    localparam logic [1:0] c_m2r_pc     = 2'b10;

    // ALU operand muxes
    localparam logic       c_srca_pc     = 1'b0;
    localparam logic       c_srca_rs     = 1'b1;
    localparam logic [1:0] c_srcb_rt     = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    // Complete set of control outputs, gated as one bundle during reset
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] other;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

endpackage : arc_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_other_dec.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_other_dec
// Description : Combinational opcode decoder producing the instruction class
//               and the I-class Other code handed to ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_other_dec
    import arc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_cls,
    output logic [3:0] o_other
);

    // Classify the opcode and look up its I-class ALU code
    always_comb begin
        o_cls   = CLS_ILL;
        o_other = c_other_add;
        case (i_opcode)
            c_op_rtype: o_cls = CLS_R;
            c_op_j:     o_cls = CLS_J;
            c_op_jal:   o_cls = CLS_JAL;
            c_op_beq:   o_cls = CLS_BEQ;
            c_op_bne:   o_cls = CLS_BNE;
            c_op_addi, c_op_addiu: begin
                o_cls   = CLS_I;
                o_other = c_other_add;
            end
            c_op_slti, c_op_sltiu: begin
                o_cls   = CLS_I;
                o_other = c_other_slt;
            end
            c_op_andi: begin
                o_cls   = CLS_I;
                o_other = c_other_and;
            end
            c_op_ori: begin
                o_cls   = CLS_I;
                o_other = c_other_or;
            end
            c_op_xori: begin
                o_cls   = CLS_I;
                o_other = c_other_xor;
            end
            c_op_lui: begin
                o_cls   = CLS_I;
                o_other = c_other_lui;
            end
            c_op_lw:    o_cls = CLS_LW;
            c_op_sw:    o_cls = CLS_SW;
            default:    o_cls = CLS_ILL;
        endcase
    end

endmodule : ctrl_other_dec
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm
// Description : Multicycle main control FSM for the ARC MIPS core. Sequences
//               fetch/decode/execute/memory/writeback and drives all datapath
//               enables and mux selects. Memory states stall on mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module main_control_fsm
    import arc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_con_Opcode,
    input  logic       i_con_jumpreg,
    input  logic       i_con_zero,
    input  logic       i_con_mem_ready,
    output logic [1:0] o_con_AluOp,
    output logic [3:0] o_con_Other,
    output logic       o_con_PcWrite,
    output logic       o_con_PcWriteCond,
    output logic [1:0] o_con_PcSrc,
    output logic       o_con_IorD,
    output logic       o_con_MemRead,
    output logic       o_con_MemWrite,
    output logic       o_con_IrWrite,
    output logic       o_con_RegWrite,
    output logic [1:0] o_con_RegDst,
    output logic [1:0] o_con_MemToReg,
    output logic       o_con_AluSrcA,
    output logic [1:0] o_con_AluSrcB,
    output logic [3:0] o_con_state,
    output logic       o_con_illegal
);

    state_t     r_state;
    state_t     w_next;
    op_class_t  r_cls;
    logic [3:0] r_other;
    op_class_t  w_dec_cls;
    logic [3:0] w_dec_other;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    // The zero flag qualifies PcWriteCond in the datapath, not in this FSM
    logic w_unused_zero;
    assign w_unused_zero = i_con_zero;

    ctrl_other_dec u_other_dec (
        .i_opcode (i_con_Opcode),
        .o_cls    (w_dec_cls),
        .o_other  (w_dec_other)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the instruction class and Other code while IR is being decoded
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cls   <= CLS_R;
            r_other <= 4'd0;
        end else if (r_state == ST_DECODE) begin
            r_cls   <= w_dec_cls;
            r_other <= w_dec_other;
        end
    end

    // Next-state and Moore output decode; FETCH/MEM handshakes also use ready
    always_comb begin
        w_ctrl       = '0;
        w_ctrl.state = r_state;
        w_next       = r_state;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_a = c_srca_pc;
                w_ctrl.alu_src_b = c_srcb_four;
                w_ctrl.alu_op    = c_aluop_add;
                if (i_con_mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = c_pcsrc_alu;
                    w_next          = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_ctrl.alu_src_a = c_srca_pc;
                w_ctrl.alu_src_b = c_srcb_imm_sh;
                w_ctrl.alu_op    = c_aluop_add;
                case (w_dec_cls)
                    CLS_R:            w_next = ST_EXEC_R;
                    CLS_J, CLS_JAL:   w_next = ST_JUMP;
                    CLS_BEQ, CLS_BNE: w_next = ST_BRANCH;
                    CLS_I:            w_next = ST_EXEC_I;
                    CLS_LW, CLS_SW:   w_next = ST_MEM_ADDR;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_next         = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                w_ctrl.alu_src_a = c_srca_rs;
                w_ctrl.alu_src_b = c_srcb_rt;
                w_ctrl.alu_op    = c_aluop_funct;
                if (i_con_jumpreg) begin
                    // jr: load PC from rs and skip writeback entirely
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = c_pcsrc_rs;
                    w_next          = ST_FETCH;
                end else begin
                    w_next = ST_R_WB;
                end
            end
            ST_R_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rd;
                w_ctrl.mem_to_reg = c_m2r_aluout;
                w_next            = ST_FETCH;
            end
            ST_EXEC_I: begin
                w_ctrl.alu_src_a = c_srca_rs;
                w_ctrl.alu_src_b = c_srcb_imm;
                w_ctrl.alu_op    = c_aluop_other;
                w_ctrl.other     = r_other;
                w_next           = ST_I_WB;
            end
            ST_I_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rt;
                w_ctrl.mem_to_reg = c_m2r_aluout;
                w_ctrl.other      = r_other;
                w_next            = ST_FETCH;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a     = c_srca_rs;
                w_ctrl.alu_src_b     = c_srcb_rt;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_src        = c_pcsrc_aluout;
                if (r_cls == CLS_BNE) begin
                    // Code 5 raises zero on inequality, so PcWriteCond works for bne
                    w_ctrl.alu_op = c_aluop_other;
                    w_ctrl.other  = c_other_bne;
                end else begin
                    w_ctrl.alu_op = c_aluop_sub;
                end
                w_next = ST_FETCH;
            end
            ST_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = c_pcsrc_jump;
                if (r_cls == CLS_JAL) begin
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.reg_dst    = c_regdst_ra;
                    w_ctrl.mem_to_reg = c_m2r_pc;
                    w_ctrl.other      = c_other_jal;
                end
                w_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = c_srca_rs;
                w_ctrl.alu_src_b = c_srcb_imm;
                w_ctrl.alu_op    = c_aluop_add;
                w_next           = (r_cls == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (i_con_mem_ready) begin
                    w_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = c_regdst_rt;
                w_ctrl.mem_to_reg = c_m2r_mdr;
                w_next            = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (i_con_mem_ready) begin
                    w_next = ST_FETCH;
                end
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Reset forces every output low immediately, independent of the clock
    always_comb begin
        w_out = w_ctrl;
        if (!i_rst_n) begin
            w_out = '0;
        end
    end

    assign o_con_PcWrite     = w_out.pc_write;
    assign o_con_PcWriteCond = w_out.pc_write_cond;
    assign o_con_PcSrc       = w_out.pc_src;
    assign o_con_IorD        = w_out.iord;
    assign o_con_MemRead     = w_out.mem_read;
    assign o_con_MemWrite    = w_out.mem_write;
    assign o_con_IrWrite     = w_out.ir_write;
    assign o_con_RegWrite    = w_out.reg_write;
    assign o_con_RegDst      = w_out.reg_dst;
    assign o_con_MemToReg    = w_out.mem_to_reg;
    assign o_con_AluSrcA     = w_out.alu_src_a;
    assign o_con_AluSrcB     = w_out.alu_src_b;
    assign o_con_AluOp       = w_out.alu_op;
    assign o_con_Other       = w_out.other;
    assign o_con_illegal     = w_out.illegal;
    assign o_con_state       = w_out.state;

endmodule : main_control_fsm
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_control_fsm
// Description : Self-checking bench for main_control_fsm. Directed scenarios
//               followed by random instructions, each cycle compared against
//               an opcode-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;
    import arc_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       jumpreg;
    logic       zero;
    logic       ready;
    logic [1:0] aluop;
    logic [3:0] other;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] st;
    logic       ill;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] regdst;
        logic [1:0] m2r;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [3:0] other;
        logic       ill;
        logic [3:0] st;
    } outs_t;

    main_control_fsm dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_con_Opcode      (opcode),
        .i_con_jumpreg     (jumpreg),
        .i_con_zero        (zero),
        .i_con_mem_ready   (ready),
        .o_con_AluOp       (aluop),
        .o_con_Other       (other),
        .o_con_PcWrite     (pcw),
        .o_con_PcWriteCond (pcwc),
        .o_con_PcSrc       (pcsrc),
        .o_con_IorD        (iord),
        .o_con_MemRead     (mr),
        .o_con_MemWrite    (mw),
        .o_con_IrWrite     (irw),
        .o_con_RegWrite    (rw),
        .o_con_RegDst      (regdst),
        .o_con_MemToReg    (m2r),
        .o_con_AluSrcA     (srca),
        .o_con_AluSrcB     (srcb),
        .o_con_state       (st),
        .o_con_illegal     (ill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t sample();
        outs_t s;
        s = {pcw, pcwc, pcsrc, iord, mr, mw, irw, rw, regdst, m2r,
             srca, srcb, aluop, other, ill, st};
        return s;
    endfunction

    function automatic bit is_legal(int op);
        return (op == 0) || (op == 2) || (op == 3) || (op == 4) || (op == 5) ||
               (op >= 8 && op <= 15) || (op == 35) || (op == 43);
    endfunction

    // I-class ALU code table from the instruction set definition
    function automatic logic [3:0] other_of(int op);
        case (op)
            8, 9:    return 4'd0;
            10, 11:  return 4'd6;
            12:      return 4'd1;
            13:      return 4'd2;
            14:      return 4'd3;
            15:      return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Expected control word for one phase of instruction 'op'
    function automatic outs_t exp_out(state_t ph, int op, bit rdy, bit jr);
        outs_t e;
        e    = '0;
        e.st = ph;
        case (ph)
            ST_FETCH: begin
                e.mr = 1; e.srcb = 2'b01;
                if (rdy) begin e.irw = 1; e.pcw = 1; end
            end
            ST_DECODE:   begin e.srcb = 2'b11; e.ill = !is_legal(op); end
            ST_EXEC_R: begin
                e.srca = 1; e.aluop = 2'b10;
                if (jr) begin e.pcw = 1; e.pcsrc = 2'b11; end
            end
            ST_R_WB:     begin e.rw = 1; e.regdst = 2'b01; end
            ST_EXEC_I:   begin e.srca = 1; e.srcb = 2'b10; e.aluop = 2'b11; e.other = other_of(op); end
            ST_I_WB:     begin e.rw = 1; e.other = other_of(op); end
            ST_BRANCH: begin
                e.srca = 1; e.pcwc = 1; e.pcsrc = 2'b01;
                if (op == 5) begin e.aluop = 2'b11; e.other = 4'd5; end
                else e.aluop = 2'b01;
            end
            ST_JUMP: begin
                e.pcw = 1; e.pcsrc = 2'b10;
                if (op == 3) begin e.rw = 1; e.regdst = 2'b10; e.m2r = 2'b10; e.other = 4'd8; end
            end
            ST_MEM_ADDR: begin e.srca = 1; e.srcb = 2'b10; end
            ST_MEM_RD:   begin e.mr = 1; e.iord = 1; end
            ST_MEM_WB:   begin e.rw = 1; e.m2r = 2'b01; end
            ST_MEM_WR:   begin e.mw = 1; e.iord = 1; end
            default:     e = '0;
        endcase
        return e;
    endfunction

    task automatic check(string tag, outs_t got, outs_t exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare settled outputs, advance the clock
    task automatic do_cycle(state_t ph, int op, bit rdy, bit jr);
        ready   = rdy;
        jumpreg = jr;
        zero    = 1'($urandom);
        opcode  = (ph == ST_FETCH) ? 6'($urandom) : 6'(op);
        #2;
        check($sformatf("op%0d_ph%0d", op, ph), sample(), exp_out(ph, op, rdy, jr));
        @(posedge clk);
        #1;
    endtask

    // Phases following DECODE, built from the instruction's semantics
    task automatic build_plan(int op, bit jr, output state_t plan[$]);
        plan = {};
        if (op == 0) begin
            plan.push_back(ST_EXEC_R);
            if (!jr) plan.push_back(ST_R_WB);
        end else if (op == 2 || op == 3) begin
            plan.push_back(ST_JUMP);
        end else if (op == 4 || op == 5) begin
            plan.push_back(ST_BRANCH);
        end else if (op >= 8 && op <= 15) begin
            plan.push_back(ST_EXEC_I);
            plan.push_back(ST_I_WB);
        end else if (op == 35) begin
            plan.push_back(ST_MEM_ADDR);
            plan.push_back(ST_MEM_RD);
            plan.push_back(ST_MEM_WB);
        end else if (op == 43) begin
            plan.push_back(ST_MEM_ADDR);
            plan.push_back(ST_MEM_WR);
        end
    endtask

    task automatic run_instr(int op, bit jr, int fetch_wait, int mem_wait);
        state_t plan[$];
        build_plan(op, jr, plan);
        for (int k = 0; k < fetch_wait; k++) do_cycle(ST_FETCH, op, 1'b0, jr);
        do_cycle(ST_FETCH, op, 1'b1, jr);
        do_cycle(ST_DECODE, op, 1'($urandom), jr);
        foreach (plan[i]) begin
            if (plan[i] == ST_MEM_RD || plan[i] == ST_MEM_WR) begin
                for (int k = 0; k < mem_wait; k++) do_cycle(plan[i], op, 1'b0, jr);
                do_cycle(plan[i], op, 1'b1, jr);
            end else begin
                do_cycle(plan[i], op, 1'($urandom), jr);
            end
        end
    endtask

    initial begin
        int ops[22] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43,
                        1, 6, 7, 20, 63, 17, 40};
        rst_n   = 1'b0;
        ready   = 1'b1;
        jumpreg = 1'b0;
        zero    = 1'b0;
        opcode  = 6'd0;
        #1;
        check("reset_outputs_zero", sample(), outs_t'('0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("reset_release_fetch", sample(), exp_out(ST_FETCH, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        // Directed scenarios
        run_instr(0, 1'b0, 0, 0);    // add: R-type with writeback
        run_instr(35, 1'b0, 0, 3);   // lw with three memory wait states
        run_instr(5, 1'b0, 0, 0);    // bne
        run_instr(4, 1'b0, 1, 0);    // beq after one fetch stall
        run_instr(13, 1'b0, 0, 0);   // ori
        run_instr(3, 1'b0, 0, 0);    // jal
        run_instr(2, 1'b0, 0, 0);    // j
        run_instr(0, 1'b1, 0, 0);    // jr
        run_instr(63, 1'b0, 0, 0);   // illegal opcode 0x3F
        run_instr(43, 1'b0, 2, 1);   // sw with stalls

        // sw interrupted by reset while the write is pending
        do_cycle(ST_FETCH, 43, 1'b1, 1'b0);
        do_cycle(ST_DECODE, 43, 1'b1, 1'b0);
        do_cycle(ST_MEM_ADDR, 43, 1'b0, 1'b0);
        do_cycle(ST_MEM_WR, 43, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_memwr", sample(), outs_t'('0));
        @(posedge clk);
        #1;
        check("reset_held_zero", sample(), outs_t'('0));
        @(negedge clk);
        ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("restart_fetch", sample(), exp_out(ST_FETCH, 0, 1'b0, 1'b0));
        @(posedge clk);
        #1;

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 21)], 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_main_control_fsm
`default_nettype wire
